uart_rx_fifo: RTL

//   Receive-side buffer directly downstream of uart_receiver. Captures each

---
 rtl/uart_rx_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side circular buffer sitting directly behind uart_receiver. Every
//   completed byte (rising edge of rx_ready) is stored together with its
//   framing-error flag, and the host drains entries through a registered,
//   one-cycle-latency read handshake. Overflow is flagged (sticky) and
//   framing-error bytes are counted with saturation.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   rx_ready       byte-complete indication from uart_receiver (level)
//   rx_data        received byte, valid while rx_ready=1
//   rx_error       framing error flag for rx_data
//   rd_en          host read request, one entry per cycle
//   rd_data        popped byte (registered)
//   rd_err         error flag stored with the popped byte
//   rd_valid       one-cycle pulse: rd_data/rd_err were updated
//   empty, full    occupancy flags, derived from count
//   count          number of stored entries (ADDR_BITS+1 bits)
//   overflow       sticky: a byte arrived while the FIFO was full
//   clr_overflow   synchronous clear of overflow (a new drop wins)
//   err_count      saturating count of bytes received with rx_error=1
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int ADDR_BITS    = 4,
    parameter int DROP_ERRORED = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_ready,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_error,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_err,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    input  logic                 clr_overflow,
    output logic [7:0]           err_count
);

    localparam int                 DEPTH   = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    // Each entry is {error flag, data byte}.
    logic [DATA_BITS:0]   mem_r [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_r;
    logic [ADDR_BITS-1:0] rd_ptr_r;
    logic                 rx_ready_d_r;

    logic                 wr_evt_s;
    logic                 keep_s;
    logic                 pop_s;
    logic                 store_s;
    logic                 drop_s;
    logic [ADDR_BITS:0]   count_nxt_s;

    // Write/read qualification: edge detect, error policy, full/empty gating.
    always_comb begin
        wr_evt_s = rx_ready & ~rx_ready_d_r;
        if ((DROP_ERRORED != 0) && rx_error) begin
            keep_s = 1'b0;
        end else begin
            keep_s = 1'b1;
        end
        pop_s = rd_en & ~empty;
        // A pop on a full FIFO frees a slot in the same cycle, so the byte fits.
        store_s = wr_evt_s & keep_s & (~full | pop_s);
        drop_s  = wr_evt_s & keep_s & full & ~pop_s;
    end

    // Next occupancy: +1 on store, -1 on pop, unchanged on both or neither.
    always_comb begin
        case ({store_s, pop_s})
            2'b10:   count_nxt_s = count + CNT_ONE;
            2'b01:   count_nxt_s = count - CNT_ONE;
            default: count_nxt_s = count;
        endcase
    end

    // Storage array; contents need no reset since count gates every access.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= {rx_error, rx_data};
        end
    end

    // Pointers, occupancy and flags derived from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {ADDR_BITS{1'b0}};
            rd_ptr_r     <= {ADDR_BITS{1'b0}};
            count        <= {(ADDR_BITS + 1){1'b0}};
            empty        <= 1'b1;
            full         <= 1'b0;
            rx_ready_d_r <= 1'b0;
        end else begin
            rx_ready_d_r <= rx_ready;
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count <= count_nxt_s;
            empty <= (count_nxt_s == {(ADDR_BITS + 1){1'b0}});
            full  <= (count_nxt_s == DEPTH_C);
        end
    end

    // Registered read port; rd_data/rd_err hold their value between pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= {DATA_BITS{1'b0}};
            rd_err   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_s;
            if (pop_s) begin
                {rd_err, rd_data} <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky overflow (a drop beats a simultaneous clear) and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (drop_s) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            // Errored bytes are counted even when they are not stored.
            if (wr_evt_s && rx_error && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
